// File: rtl/apb_led_pkg.sv
// apb_led_pkg: shared constants and types for the APB LED blinker.
//   - word offsets (PADDR[4:2]) of every register
//   - CTRL bit positions
//   - APB read FSM state enum
package apb_led_pkg;

    localparam logic [2:0] ADDR_CTRL    = 3'd0;
    localparam logic [2:0] ADDR_PERIOD  = 3'd1;
    localparam logic [2:0] ADDR_PATTERN = 3'd2;
    localparam logic [2:0] ADDR_LEDMAN  = 3'd3;
    localparam logic [2:0] ADDR_STATUS  = 3'd4;
    localparam logic [2:0] ADDR_IRQ     = 3'd5;

    localparam int CTRL_EN   = 0;
    localparam int CTRL_MODE = 1;
    localparam int CTRL_IE   = 2;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_WAIT = 2'd1,
        RD_DONE = 2'd2
    } apb_state_e;

endpackage

// File: rtl/led_blink_core.sv
// led_blink_core: prescaler + LED toggle engine.
//   clk, rst_n   clock, synchronous active-low reset
//   en           run the prescaler (held at 0 when low)
//   period       half-period in cycles; 0 behaves as 1
//   pattern      XOR mask applied to led_state at each toggle
//   clr          restart the prescaler; suppresses a coincident toggle
//   led_state    current blink value
//   tog_cnt      wrapping toggle counter
//   tog_pulse    high in the cycle whose closing edge toggles
module led_blink_core #(
    parameter int NUM_LEDS = 8,
    parameter int CNT_W    = 32,
    parameter int TOG_W    = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                en,
    input  logic [CNT_W-1:0]    period,
    input  logic [NUM_LEDS-1:0] pattern,
    input  logic                clr,
    output logic [NUM_LEDS-1:0] led_state,
    output logic [TOG_W-1:0]    tog_cnt,
    output logic                tog_pulse
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] last;
    logic             term;

    // Terminal count is P-1 with P = max(period, 1).
    assign last      = (period == '0) ? '0 : period - CNT_W'(1);
    assign term      = (cnt_q == last);
    // A clearing register write on the terminal edge wins over the toggle.
    assign tog_pulse = en & term & ~clr;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            led_state <= '0;
            tog_cnt   <= '0;
        end else begin
            if (!en || clr || term) cnt_q <= '0;
            else                    cnt_q <= cnt_q + CNT_W'(1);
            if (tog_pulse) begin
                led_state <= led_state ^ pattern;
                tog_cnt   <= tog_cnt + TOG_W'(1);
            end
        end
    end

endmodule

// File: rtl/apb_led_blink_slave.sv
// apb_led_blink_slave: APB3 completer driving a bank of LEDs.
//   PCLK, PRESERN        clock, synchronous active-low reset
//   PSEL/PENABLE/PWRITE  APB control; PADDR[4:2] selects the register
//   PWDATA / PRDATA      write / read data
//   PREADY, PSLVERR      zero-wait writes, one-wait reads; error on unmapped/RO
//   IRQ                  toggle interrupt (only with APB_LED_IRQ_EN defined)
//   LED                  registered LED drive, active-high
// Optional feature macro: APB_LED_IRQ_EN (adds IRQ port, 0x14 W1C, CTRL.IE).
module apb_led_blink_slave
    import apb_led_pkg::*;
#(
    parameter int NUM_LEDS = 8,
    parameter int CNT_W    = 32,
    parameter int TOG_W    = 16
) (
    input  logic                PCLK,
    input  logic                PRESERN,
    input  logic                PSEL,
    input  logic                PENABLE,
    input  logic                PWRITE,
    input  logic [4:0]          PADDR,
    input  logic [31:0]         PWDATA,
    output logic [31:0]         PRDATA,
    output logic                PREADY,
    output logic                PSLVERR,
`ifdef APB_LED_IRQ_EN
    output logic                IRQ,
`endif
    output logic [NUM_LEDS-1:0] LED
);

`ifdef APB_LED_IRQ_EN
    localparam logic [2:0] CTRL_WMASK = 3'b111;
`else
    localparam logic [2:0] CTRL_WMASK = 3'b011;
`endif

    apb_state_e          state_q;
    logic [2:0]          ctrl_q;
    logic [CNT_W-1:0]    period_q;
    logic [NUM_LEDS-1:0] pattern_q;
    logic [NUM_LEDS-1:0] ledman_q;
    logic [NUM_LEDS-1:0] led_q, led_d;
    logic [31:0]         prdata_q;
    logic                rd_err_q;
    logic                irq_pend_q;

    logic [2:0]          addr;
    logic                wr_acc, wr_ok, rd_ok, wr_en, blink_clr;
    logic [31:0]         rd_data;
    logic [NUM_LEDS-1:0] led_state;
    logic [TOG_W-1:0]    tog_cnt;
    logic                tog_pulse;
    logic                unused_ok;

    assign addr      = PADDR[4:2];
    assign wr_acc    = PSEL & PENABLE & PWRITE;
    assign wr_en     = wr_acc & wr_ok;
    assign blink_clr = wr_en & ((addr == ADDR_CTRL) | (addr == ADDR_PERIOD));
    assign unused_ok = ^{PADDR[1:0], PWDATA};

    always_comb begin
        wr_ok = 1'b0;
        rd_ok = 1'b0;
        case (addr)
            ADDR_CTRL, ADDR_PERIOD, ADDR_PATTERN, ADDR_LEDMAN: begin
                wr_ok = 1'b1;
                rd_ok = 1'b1;
            end
            ADDR_STATUS: rd_ok = 1'b1;
`ifdef APB_LED_IRQ_EN
            ADDR_IRQ: begin
                wr_ok = 1'b1;
                rd_ok = 1'b1;
            end
`endif
            default: ;
        endcase
    end

    always_comb begin
        rd_data = '0;
        case (addr)
            ADDR_CTRL:    rd_data = 32'(ctrl_q);
            ADDR_PERIOD:  rd_data = 32'(period_q);
            ADDR_PATTERN: rd_data = 32'(pattern_q);
            ADDR_LEDMAN:  rd_data = 32'(ledman_q);
            ADDR_STATUS: begin
                rd_data[NUM_LEDS-1:0] = led_q;
                rd_data[31:16]        = 16'(tog_cnt);
            end
`ifdef APB_LED_IRQ_EN
            ADDR_IRQ:     rd_data[0] = irq_pend_q;
`endif
            default: ;
        endcase
    end

    // Engine only runs in blink mode; manual mode keeps led_state frozen.
    led_blink_core #(.NUM_LEDS(NUM_LEDS), .CNT_W(CNT_W), .TOG_W(TOG_W)) u_core (
        .clk       (PCLK),
        .rst_n     (PRESERN),
        .en        (ctrl_q[CTRL_EN] & ~ctrl_q[CTRL_MODE]),
        .period    (period_q),
        .pattern   (pattern_q),
        .clr       (blink_clr),
        .led_state (led_state),
        .tog_cnt   (tog_cnt),
        .tog_pulse (tog_pulse)
    );

    assign led_d   = ctrl_q[CTRL_MODE] ? ledman_q : led_state;
    assign PRDATA  = prdata_q;
    assign LED     = led_q;
    assign PREADY  = wr_acc | (state_q == RD_DONE);
    assign PSLVERR = (wr_acc & ~wr_ok) | ((state_q == RD_DONE) & rd_err_q);
`ifdef APB_LED_IRQ_EN
    assign IRQ     = irq_pend_q & ctrl_q[CTRL_IE];
`endif

    always_ff @(posedge PCLK) begin
        if (!PRESERN) begin
            state_q    <= IDLE;
            ctrl_q     <= '0;
            period_q   <= CNT_W'(1);
            pattern_q  <= '1;
            ledman_q   <= '0;
            led_q      <= '0;
            prdata_q   <= '0;
            rd_err_q   <= 1'b0;
            irq_pend_q <= 1'b0;
        end else begin
            led_q <= led_d;

            case (state_q)
                IDLE: if (PSEL && !PENABLE && !PWRITE) state_q <= RD_WAIT;
                RD_WAIT: begin
                    if (!PSEL) begin
                        state_q <= IDLE;           // aborted read
                    end else if (PENABLE) begin
                        state_q  <= RD_DONE;
                        prdata_q <= rd_data;
                        rd_err_q <= ~rd_ok;
                    end
                end
                default: state_q <= IDLE;          // RD_DONE and illegal
            endcase

            if (wr_en) begin
                case (addr)
                    ADDR_CTRL:    ctrl_q    <= PWDATA[2:0] & CTRL_WMASK;
                    ADDR_PERIOD:  period_q  <= PWDATA[CNT_W-1:0];
                    ADDR_PATTERN: pattern_q <= PWDATA[NUM_LEDS-1:0];
                    ADDR_LEDMAN:  ledman_q  <= PWDATA[NUM_LEDS-1:0];
                    default: ;
                endcase
            end

`ifdef APB_LED_IRQ_EN
            // Set has priority over a coincident W1C.
            if (tog_pulse)
                irq_pend_q <= 1'b1;
            else if (wr_en && addr == ADDR_IRQ && PWDATA[0])
                irq_pend_q <= 1'b0;
`endif
        end
    end

endmodule

// File: tb/tb_apb_led_blink_slave.sv
// tb_apb_led_blink_slave: directed self-checking bench for apb_led_blink_slave.
module tb_apb_led_blink_slave;

    logic        PCLK = 1'b0;
    logic        PRESERN = 1'b0;
    logic        PSEL = 1'b0, PENABLE = 1'b0, PWRITE = 1'b0;
    logic [4:0]  PADDR = '0;
    logic [31:0] PWDATA = '0;
    logic [31:0] PRDATA;
    logic        PREADY, PSLVERR;
    logic [7:0]  LED;
`ifdef APB_LED_IRQ_EN
    logic        IRQ;
`endif

    int errors = 0;
    int checks = 0;

    apb_led_blink_slave #(.NUM_LEDS(8), .CNT_W(32), .TOG_W(16)) dut (
        .PCLK(PCLK), .PRESERN(PRESERN), .PSEL(PSEL), .PENABLE(PENABLE),
        .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA),
        .PREADY(PREADY), .PSLVERR(PSLVERR),
`ifdef APB_LED_IRQ_EN
        .IRQ(IRQ),
`endif
        .LED(LED)
    );

    always #5 PCLK = ~PCLK;

    // All tasks start and end 1 time unit after a rising edge.
    task automatic tick();
        @(posedge PCLK); #1;
    endtask

    task automatic do_reset();
        PSEL = 0; PENABLE = 0; PWRITE = 0; PRESERN = 0;
        repeat (2) @(posedge PCLK);
        #1 PRESERN = 1;
    endtask

    task automatic apb_write(input logic [4:0] a, input logic [31:0] d,
                             output logic rdy, output logic err);
        PSEL = 1; PENABLE = 0; PWRITE = 1; PADDR = a; PWDATA = d;
        @(posedge PCLK); #1 PENABLE = 1;
        #1 rdy = PREADY; err = PSLVERR;
        @(posedge PCLK); #1 PSEL = 0; PENABLE = 0; PWRITE = 0;
    endtask

    task automatic apb_read(input logic [4:0] a, output logic [31:0] d,
                            output logic err, output int nwait);
        PSEL = 1; PENABLE = 0; PWRITE = 0; PADDR = a;
        @(posedge PCLK); #1 PENABLE = 1;
        #1 nwait = 0;
        while (!PREADY && nwait < 8) begin
            @(posedge PCLK); #2; nwait++;
        end
        d = PRDATA; err = PSLVERR;
        @(posedge PCLK); #1 PSEL = 0; PENABLE = 0;
    endtask

    task automatic test_reset();
        logic [31:0] rd; logic er; int nw;
        logic [4:0]  addrs [5] = '{5'h00, 5'h04, 5'h08, 5'h0C, 5'h10};
        logic [31:0] exps  [5] = '{32'h0, 32'h1, 32'hFF, 32'h0, 32'h0};
        PRESERN = 0; PSEL = 0; PENABLE = 0; PWRITE = 0;
        repeat (2) @(posedge PCLK);
        #1;
        checks++;
        if ({PRDATA, PREADY, PSLVERR, LED} !== 42'h0) begin
            errors++;
            $display("FAIL reset_outputs: got PRDATA=%h PREADY=%b PSLVERR=%b LED=%h, want all 0",
                     PRDATA, PREADY, PSLVERR, LED);
        end
        PRESERN = 1;
        for (int i = 0; i < 5; i++) begin
            apb_read(addrs[i], rd, er, nw);
            checks++;
            if (rd !== exps[i] || er !== 1'b0) begin
                errors++;
                $display("FAIL reset_reg[%h]: got %h err=%b, want %h err=0", addrs[i], rd, er, exps[i]);
            end
            checks++;
            if (nw !== 1) begin
                errors++;
                $display("FAIL read_wait[%h]: got %0d wait cycles, want 1", addrs[i], nw);
            end
        end
    endtask

    task automatic test_blink();
        logic [31:0] rd; logic er, rdy; int nw;
        logic [7:0] exp;
        do_reset();
        apb_write(5'h04, 32'd4, rdy, er);
        apb_write(5'h00, 32'h1, rdy, er);
        for (int k = 1; k <= 12; k++) begin
            tick();
            exp = (((k - 1) / 4) % 2 == 1) ? 8'hFF : 8'h00;
            checks++;
            if (LED !== exp) begin
                errors++;
                $display("FAIL blink_led[k=%0d]: got %h, want %h", k, LED, exp);
            end
        end
        apb_read(5'h10, rd, er, nw);
        checks++;
        if (rd !== 32'h0003_00FF) begin
            errors++;
            $display("FAIL blink_status: got %h, want 000300ff", rd);
        end
    endtask

    task automatic test_period0_stop();
        logic [31:0] rd; logic er, rdy; int nw;
        logic [7:0] exp;
        do_reset();
        apb_write(5'h04, 32'd0, rdy, er);
        apb_write(5'h00, 32'h1, rdy, er);
        for (int k = 1; k <= 6; k++) begin
            tick();
            exp = (k % 2 == 0) ? 8'hFF : 8'h00;
            checks++;
            if (LED !== exp) begin
                errors++;
                $display("FAIL period0_led[k=%0d]: got %h, want %h", k, LED, exp);
            end
        end
        apb_write(5'h00, 32'h0, rdy, er);   // lands on a would-be toggle edge
        repeat (5) tick();
        checks++;
        if (LED !== 8'hFF) begin
            errors++;
            $display("FAIL frozen_led: got %h, want ff", LED);
        end
        apb_read(5'h10, rd, er, nw);
        checks++;
        if (rd !== 32'h0007_00FF) begin
            errors++;
            $display("FAIL frozen_status: got %h, want 000700ff", rd);
        end
    endtask

    task automatic test_manual();
        logic er, rdy;
        do_reset();
        apb_write(5'h00, 32'h1, rdy, er);   // blink with PERIOD=1
        apb_write(5'h0C, 32'hA5, rdy, er);
        apb_write(5'h00, 32'h3, rdy, er);   // manual; led_state holds ff
        checks++;
        if (LED !== 8'hFF) begin
            errors++;
            $display("FAIL manual_pre: got %h, want ff", LED);
        end
        tick();
        checks++;
        if (LED !== 8'hA5) begin
            errors++;
            $display("FAIL manual_led: got %h, want a5", LED);
        end
        apb_write(5'h00, 32'h0, rdy, er);
        checks++;
        if (LED !== 8'hA5) begin
            errors++;
            $display("FAIL manual_exit_lag: got %h, want a5", LED);
        end
        tick();
        checks++;
        if (LED !== 8'hFF) begin
            errors++;
            $display("FAIL manual_exit: got %h, want ff", LED);
        end
    endtask

    task automatic test_errors();
        logic [31:0] rd; logic er, rdy; int nw;
        do_reset();
        apb_write(5'h04, 32'd7, rdy, er);
        checks++;
        if (rdy !== 1'b1 || er !== 1'b0) begin
            errors++;
            $display("FAIL write_ok: got PREADY=%b PSLVERR=%b, want 1 0", rdy, er);
        end
        apb_write(5'h10, 32'hFFFF_FFFF, rdy, er);
        checks++;
        if (rdy !== 1'b1 || er !== 1'b1) begin
            errors++;
            $display("FAIL write_ro: got PREADY=%b PSLVERR=%b, want 1 1", rdy, er);
        end
        apb_write(5'h18, 32'h3, rdy, er);
        checks++;
        if (er !== 1'b1) begin
            errors++;
            $display("FAIL write_unmapped: got PSLVERR=%b, want 1", er);
        end
`ifndef APB_LED_IRQ_EN
        apb_write(5'h14, 32'h1, rdy, er);
        checks++;
        if (er !== 1'b1) begin
            errors++;
            $display("FAIL write_irq_absent: got PSLVERR=%b, want 1", er);
        end
        apb_write(5'h00, 32'h4, rdy, er);   // IE bit does not exist
        apb_read(5'h00, rd, er, nw);
        checks++;
        if (rd !== 32'h0) begin
            errors++;
            $display("FAIL ctrl_ie_absent: got %h, want 0", rd);
        end
`endif
        apb_read(5'h18, rd, er, nw);
        checks++;
        if (er !== 1'b1 || nw !== 1) begin
            errors++;
            $display("FAIL read_unmapped: got PSLVERR=%b waits=%0d, want 1 1", er, nw);
        end
        apb_read(5'h04, rd, er, nw);
        checks++;
        if (rd !== 32'd7 || er !== 1'b0) begin
            errors++;
            $display("FAIL period_kept: got %h err=%b, want 7 err=0", rd, er);
        end
        apb_read(5'h10, rd, er, nw);
        checks++;
        if (rd !== 32'h0) begin
            errors++;
            $display("FAIL status_kept: got %h, want 0", rd);
        end
        checks++;
        if (LED !== 8'h00) begin
            errors++;
            $display("FAIL led_kept: got %h, want 00", LED);
        end
    endtask

`ifdef APB_LED_IRQ_EN
    task automatic test_irq();
        logic er, rdy;
        do_reset();
        apb_write(5'h04, 32'd2, rdy, er);
        apb_write(5'h00, 32'h5, rdy, er);   // EN | IE
        tick();
        checks++;
        if (IRQ !== 1'b0) begin
            errors++;
            $display("FAIL irq_before: got %b, want 0", IRQ);
        end
        tick();
        checks++;
        if (IRQ !== 1'b1) begin
            errors++;
            $display("FAIL irq_rise: got %b, want 1", IRQ);
        end
        apb_write(5'h14, 32'h1, rdy, er);   // on a toggle edge
        checks++;
        if (IRQ !== 1'b1 || er !== 1'b0) begin
            errors++;
            $display("FAIL irq_set_wins: got IRQ=%b err=%b, want 1 0", IRQ, er);
        end
        tick();
        apb_write(5'h14, 32'h1, rdy, er);   // on a non-toggle edge
        checks++;
        if (IRQ !== 1'b0) begin
            errors++;
            $display("FAIL irq_clear: got %b, want 0", IRQ);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_blink();
        test_period0_stop();
        test_manual();
        test_errors();
`ifdef APB_LED_IRQ_EN
        test_irq();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, want completion");
        $fatal(1);
    end

endmodule
